// File: rtl/sram_like_resp.sv
// Responder end of an SRAM-like req/addr_ok/data_ok interface: an in-order request queue
// in front of a word-addressed memory, with a programmable response wait.
module sram_like_resp #(
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned AW      = 10,
   parameter int unsigned LATENCY = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        addr_hold,
   input  logic        resp_hold,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW   = $clog2(DEPTH + 1);
   localparam int unsigned LW   = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [LW-1:0] LAT  = LW'(LATENCY);

   typedef struct packed {
      logic          wr;
      logic [3:0]    be;
      logic [AW-1:0] idx;
      logic [31:0]   wdata;
   } entry_t;

   logic [31:0]   mem [2**AW];
   entry_t        queue [DEPTH];
   entry_t        head;
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic [LW-1:0] cnt;
   logic [3:0]    be;
   logic          push, pop;
   logic          unused_addr;

   assign unused_addr = ^addr[31:AW+2];

   function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) return '0;
      return p + PW'(1);
   endfunction

   // Misaligned or illegal sizes leave be = 0: the request still completes, nothing is written.
   always_comb begin
      be = 4'b0000;
      case (size)
         2'd0: be = 4'b0001 << addr[1:0];
         2'd1: begin
            if (addr[1:0] == 2'd0)      be = 4'b0011;
            else if (addr[1:0] == 2'd2) be = 4'b1100;
         end
         2'd2: begin
            if (addr[1:0] == 2'd0) be = 4'b1111;
         end
         default: be = 4'b0000;
      endcase
   end

   assign head    = queue[rd_ptr];
   assign addr_ok = !rst && req && !addr_hold && (count != FULL);
   assign data_ok = !rst && (count != '0) && !resp_hold && (cnt == LAT);
   assign rdata   = (data_ok && !head.wr) ? mem[head.idx] : '0;
   assign push    = req && addr_ok;
   assign pop     = data_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
         // The wait counter only advances while a head exists and is not held; it never passes LAT.
         if (pop)                               cnt <= '0;
         else if ((count != '0) && !resp_hold) cnt <= cnt + LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         queue[wr_ptr] <= '{wr: wr, be: be, idx: addr[AW+1:2], wdata: wdata};
      end
      if (pop && head.wr) begin
         for (int b = 0; b < 4; b++) begin
            if (head.be[b]) mem[head.idx][8*b +: 8] <= head.wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: doc/sram_like_resp.md
Name: sram_like_resp

Overview:
- Responder end of the core's SRAM-like request interface (req / addr_ok / data_ok): accepts requests, queues them in order, commits stores and returns load data after a programmable wait.
- Used as the data-side (or inst-side) memory model behind the core and as the slave stage in front of the cache/AXI bridge.
- Exercises the core's stall and refresh control with back-to-back, queued and held responses.

Parameters:
- DEPTH, 2, max outstanding accepted-but-unanswered requests (power of two, >=1).
- AW, 10, word-address bits of the internal memory (2^AW 32-bit words).
- LATENCY, 0, extra wait cycles between a request reaching queue head and its data_ok (>=0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  request valid.
- wr  in  1  1 = store, 0 = load.
- size  in  2  0 byte, 1 half, 2 word, 3 illegal.
- addr  in  32  byte address.
- wdata  in  32  store data, byte lanes already aligned to addr.
- addr_hold  in  1  test hook; forces addr_ok low.
- resp_hold  in  1  test hook; freezes wait counter and forces data_ok low.
- addr_ok  out  1  request accepted this cycle.
- data_ok  out  1  head request completes this cycle.
- rdata  out  32  load data, valid when data_ok and head is a load.

Behaviour:
- Reset: queue empty, rd/wr pointers and count 0, wait counter 0. addr_ok, data_ok and rdata read 0 while rst is high and after release until a request is accepted. Memory contents are not reset.
- Reset asserted mid-operation discards all queued requests; no data_ok is issued for them.
- Accept:
  - addr_ok = req & !addr_hold & (count != DEPTH). Combinational; count is the registered value, with no same-cycle pop bypass.
  - On req & addr_ok, push {wr, be, word index addr[AW+1:2], wdata}.
  - Upper address bits are ignored (wrap modulo 2^AW words).
- Byte enables from size/addr[1:0]:
  - size 0: be = 1 << addr[1:0].
  - size 1: addr[1:0]=0 -> 0011; addr[1:0]=2 -> 1100.
  - size 2: addr[1:0]=0 -> 1111.
  - Any other combination: be = 0000. No memory write, but the request still receives a data_ok (loads return the word normally).
- Wait counter cnt:
  - Runs only while the queue is non-empty and resp_hold = 0.
  - Increments from 0 each cycle; held while resp_hold = 1.
  - Cleared to 0 on every pop.
- Response:
  - data_ok = (count != 0) & !resp_hold & (cnt == LATENCY). Combinational.
  - In the data_ok cycle, rdata = memory word at the head index (asynchronous read); rdata = 0 when the head is a store or no data_ok.
  - A store head writes its enabled bytes at the clock edge ending the data_ok cycle.
  - The head is popped at that same edge.
- Timing:
  - Request accepted in cycle T into an empty queue -> data_ok in cycle T+1+LATENCY (absent resp_hold).
  - With LATENCY = 0 and continuous requests, data_ok is high every cycle, one cycle behind addr_ok.
  - Queued requests complete strictly in acceptance order, each LATENCY+1 cycles after the previous pop.
- Ordering: a load following a store to the same word observes the store (the store commits at its own pop, which is earlier).
- Full: with count == DEPTH, addr_ok = 0 even if a pop occurs that cycle. Acceptance resumes the next cycle.
- Simultaneous push and pop (count not full): count unchanged, both pointers advance (wrap modulo DEPTH).
- Empty: data_ok = 0 and cnt is held at 0.

Test Plan:
- Reset, then idle: rst=1 for 3 cycles, req=0 -> addr_ok=0, data_ok=0, rdata=0 throughout; release rst -> outputs stay 0.
- Word store then load, LATENCY=0: store 0xDEADBEEF to 0x40 at cycle T -> addr_ok=1 at T, data_ok=1 at T+1. Load 0x40 at T+1 -> data_ok at T+2 with rdata=0xDEADBEEF.
- Partial stores: word 0x11223344 at 0x80, then byte 0xAA at 0x81 (wdata 0x0000AA00), then half 0xBBBB at 0x82 (wdata 0xBBBB0000); load 0x80 -> rdata=0xBBBBAA44. A half store at 0x81 changes nothing but still gets data_ok.
- Full and back-pressure, DEPTH=2, LATENCY=3: req held high from T -> addr_ok at T and T+1, low from T+2; first data_ok at T+4. No acceptance in the T+4 pop cycle; acceptance resumes T+5; second data_ok at T+8.
- resp_hold: load accepted at T with LATENCY=0, resp_hold=1 for T+1..T+3 -> data_ok=0 there; data_ok=1 at T+4 with the correct rdata. addr_hold=1 forces addr_ok=0 while req=1.
- Reset mid-flight: two loads queued, rst pulsed for one cycle before the first data_ok -> neither data_ok appears. A new load afterwards returns the memory data written before the reset.
